// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the F/X/W pipeline sequencer.
// Holds the sequencer state encoding, the NOP word and forwarding encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic FWD_RF = 1'b0;
    localparam logic FWD_WB = 1'b1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: DMEM request/acknowledge handshake between sequencer and DMEM.
// The sequencer holds the master modport, the memory holds the slave.
interface pipe_ctrl_if;

    logic dmem_req;
    logic dmem_ack;

    modport master (
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        output dmem_ack
    );

endinterface

// File: rtl/pipe_fwd_unit.sv
// pipe_fwd_unit: W->X operand forwarding comparators.
// Pure combinational; x0 is never forwarded.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] x_rs1,
    input  logic [4:0] x_rs2,
    input  logic       x_use_rs1,
    input  logic       x_use_rs2,
    input  logic [4:0] w_rd,
    input  logic       w_regwen,
    output logic       fwd_a,
    output logic       fwd_b
);

    logic w_live;

    assign w_live = w_regwen && (w_rd != 5'd0);

    assign fwd_a = (x_use_rs1 && w_live && (w_rd == x_rs1))
                 ? FWD_WB : FWD_RF;
    assign fwd_b = (x_use_rs2 && w_live && (w_rd == x_rs2))
                 ? FWD_WB : FWD_RF;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: F/X/W pipeline sequencer with DMEM handshake and timeout.
// Define PIPE_PERF_CNT_EN to add the stall_cnt/flush_cnt counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       x_rs1,
    input  logic [4:0]       x_rs2,
    input  logic             x_use_rs1,
    input  logic             x_use_rs2,
    input  logic             x_redirect,
    input  logic [4:0]       w_rd,
    input  logic             w_regwen,
    input  logic             w_mem,
    pipe_ctrl_if.master      dmem,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             x_en,
    output logic             x_kill,
    output logic             w_en,
    output logic             w_kill,
    output logic             w_wen_mask,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1)
    begin : g_param_chk
        $error("pipe_ctrl: parameter out of range");
    end

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] tmo_cnt;
    logic       adv;
    logic       tmo;
    logic       ack;

    assign ack = dmem.dmem_ack;

    pipe_fwd_unit u_fwd (
        .x_rs1     (x_rs1),
        .x_rs2     (x_rs2),
        .x_use_rs1 (x_use_rs1),
        .x_use_rs2 (x_use_rs2),
        .w_rd      (w_rd),
        .w_regwen  (w_regwen),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

    always_comb begin
        state_nx      = state;
        adv           = 1'b0;
        tmo           = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = 1'b0;
        x_en          = 1'b0;
        x_kill        = 1'b0;
        w_en          = 1'b0;
        w_kill        = 1'b0;
        w_wen_mask    = 1'b0;
        dmem.dmem_req = 1'b0;
        unique case (state)
            BOOT: begin
                x_en       = 1'b1;
                x_kill     = 1'b1;
                w_en       = 1'b1;
                w_kill     = 1'b1;
                w_wen_mask = 1'b1;
                state_nx   = RUN;
            end
            RUN: begin
                dmem.dmem_req = w_mem;
                adv           = !w_mem || ack;
                if (!adv) state_nx = MEM_WAIT;
            end
            MEM_WAIT: begin
                dmem.dmem_req = 1'b1;
                tmo           = !ack && (tmo_cnt == TMO_LAST);
                adv           = ack || tmo;
                // a timed-out load still advances, but must not write back
                w_wen_mask    = !ack;
                if (adv) state_nx = RUN;
            end
            default: state_nx = BOOT;
        endcase
        if (adv) begin
            pc_en  = 1'b1;
            x_en   = 1'b1;
            w_en   = 1'b1;
            pc_sel = x_redirect;
            x_kill = x_redirect;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BOOT;
            tmo_cnt <= 8'd0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == MEM_WAIT && !adv) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end else begin
                tmo_cnt <= 8'd0;
            end
            if (tmo) mem_err <= 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic frozen;

    assign frozen = (state != BOOT) && !adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (frozen) stall_cnt <= stall_cnt + 1'b1;
            if (adv && x_redirect) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central sequencer for the three-stage F/X/W pipeline. It owns the PC enable and redirect select, the advance/kill controls of the X and W pipeline latches, and the operand forwarding selects from W into X. It also runs the multi-cycle DMEM request/acknowledge handshake, and freezes the whole pipeline while a W-stage memory access is outstanding. It sits beside the per-stage decoders (Control_X, Control_W) and replaces their ad-hoc latch enables.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before the access is abandoned; range 1..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- x_rs1, x_rs2  in  5 each  source register indices of the instruction in X.
- x_use_rs1, x_use_rs2  in  1 each  the X instruction reads rs1 / rs2.
- x_redirect  in  1  the X instruction is a taken branch or a jump; the target is on alu_X.
- w_rd  in  5  destination register of the instruction in W.
- w_regwen  in  1  the W instruction writes the register file.
- w_mem  in  1  the W instruction is a load or store.
- dmem_ack  in  1  DMEM completes the access this cycle; read data is valid on wb_out this cycle.
- pc_en  out  1  the PC register loads.
- pc_sel  out  1  PC source: 0 = pc+4, 1 = alu_X.
- x_en  out  1  the X latches load.
- x_kill  out  1  with x_en, the X latch loads NOP (0x00000013) instead of inst_F.
- w_en  out  1  the W latches load.
- w_kill  out  1  with w_en, the W latch loads NOP.
- w_wen_mask  out  1  forces regWEn low this cycle.
- fwd_a, fwd_b  out  1 each  X operand source: 0 = register file, 1 = wb_out.
- dmem_req  out  1  DMEM access request.
- mem_err  out  1  sticky DMEM timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  present only with PIPE_PERF_CNT_EN.

## Operation
The state machine has three states: BOOT, RUN and MEM_WAIT.

BOOT (entered on reset, lasts one cycle):
- pc_en=0, x_en=1, x_kill=1, w_en=1, w_kill=1, w_wen_mask=1.
- The latches are filled with NOPs. The next state is RUN.

RUN:
- If w_mem=0, or w_mem=1 and dmem_ack=1, the pipeline advances:
  - pc_en=1, x_en=1, w_en=1.
  - If x_redirect=1: pc_sel=1 and x_kill=1, so the wrong-path instruction in F becomes a bubble. flush_cnt increments.
- If w_mem=1 and dmem_ack=0, the pipeline freezes:
  - pc_en=0, x_en=0, w_en=0.
  - The next state is MEM_WAIT. stall_cnt increments.
- dmem_req=w_mem in both cases.

MEM_WAIT:
- dmem_req=1. pc_en, x_en and w_en are held at 0, and w_wen_mask=1 so the frozen W instruction does not write repeatedly.
- The timeout counter increments every cycle. stall_cnt increments every cycle that the pipeline stays frozen.
- On dmem_ack=1: w_wen_mask=0, the pipeline advances exactly as in RUN (including any redirect), the counter is cleared, and the next state is RUN.
- On counter == MEM_TIMEOUT-1 with no ack:
  - mem_err is set; it stays set until reset.
  - The pipeline advances with w_wen_mask=1 (the load result is discarded) and the next state is RUN.

Forwarding, evaluated in all states:
- fwd_a = x_use_rs1 & w_regwen & (w_rd != 0) & (w_rd == x_rs1).
- fwd_b is the same expression using x_use_rs2 and x_rs2.
- When the W instruction is a load, its data is forwarded only in the cycle it advances (the ack cycle). X is frozen until then, so no load-use bubble is needed.

pc_sel and x_kill are 0 whenever the pipeline does not advance. A redirect is never acted on while frozen.

## Timing
- Enables, kills, forwarding selects and dmem_req are Mealy outputs: combinational from the state and the current inputs. There is no added latency.
- The state register, timeout counter, mem_err and the performance counters are registered on the rising edge of clk.
- While rst=0 the outputs take these values: state=BOOT, pc_en=0, x_en=1, x_kill=1, w_en=1, w_kill=1, w_wen_mask=1, pc_sel=0, dmem_req=0, mem_err=0, counters=0. fwd_a and fwd_b follow their equations.
- If reset is asserted mid-access, the access is abandoned and dmem_req drops immediately.
- The counters wrap modulo 2^CNT_W.
- A branch costs 1 bubble.
- A memory access costs N stall cycles, where N is the number of cycles before ack.

## Configuration
- PIPE_PERF_CNT_EN defined: stall_cnt and flush_cnt are present and count as described above.
- PIPE_PERF_CNT_EN not defined: both ports and their registers are removed. All other behaviour is identical.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum {BOOT, RUN, MEM_WAIT};
  - the NOP constant 32'h00000013;
  - the FWD_RF=0 and FWD_WB=1 encodings.
- Sub-module pipe_fwd_unit holds the two pure-combinational forwarding comparators.

## Test plan
- Reset release: first cycle shows x_kill=1, w_kill=1, pc_en=0. Second cycle shows pc_en=1 and state RUN.
- X has x_redirect=1 with w_mem=0: pc_sel=1, x_kill=1 for exactly 1 cycle, and flush_cnt increments by 1.
- Load in W with dmem_ack after 3 cycles: pc_en=0 for 3 cycles, w_wen_mask=1 during MEM_WAIT, stall_cnt increments by 3, and the pipeline advances on the ack cycle.
- w_rd=5, w_regwen=1, x_rs1=5, x_use_rs1=1: fwd_a=1. With w_rd=0 and x_rs1=0: fwd_a=0.
- w_mem=1 with ack never asserted, MEM_TIMEOUT=4: mem_err=1 after 4 cycles, the pipeline advances with w_wen_mask=1, and mem_err stays set until rst=0.
- Ack and redirect in the same cycle: advance, pc_sel=1, x_kill=1, next state RUN.
